// File: rtl/datapath_if.sv
// Control/status bundle between the control unit and the datapath.
// The control unit drives decode fields; the datapath returns Acc and flags.
interface datapath_if #(
  parameter int B = 16,
  parameter int W = 11
);
  logic [1:0]   SelA;
  logic         SelB;
  logic         WrAcc;
  logic         Op;
  logic         WrRam;
  logic         RdRam;
  logic [W-1:0] Operand;
  logic [B-1:0] Acc;
  logic         Zero;
  logic         Neg;
  logic         Ovf;

  modport master (
    output SelA, SelB, WrAcc, Op,
    output WrRam, RdRam, Operand,
    input  Acc, Zero, Neg, Ovf
  );

  modport slave (
    input  SelA, SelB, WrAcc, Op,
    input  WrRam, RdRam, Operand,
    output Acc, Zero, Neg, Ovf
  );
endinterface

// File: rtl/datapath.sv
// Accumulator-machine execution datapath: Acc, add/sub ALU,
// sign extension, data RAM, sticky overflow and a debug read port.
module datapath #(
  parameter int B = 16,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  datapath_if.slave    bus,
  input  logic [W-1:0] dbg_addr,
  output logic [B-1:0] dbg_data
);

  logic [B-1:0] mem [2**W];
  logic [B-1:0] acc_q;
  logic [B-1:0] acc_d;
  logic [B-1:0] ext;
  logic [B-1:0] ram_rd;
  logic [B-1:0] bsrc;
  logic [B-1:0] res;
  logic         ovf_q;
  logic         alu_ovf;

  assign ext    = {{(B-W){bus.Operand[W-1]}}, bus.Operand};
  assign ram_rd = bus.RdRam ? mem[bus.Operand] : '0;
  assign bsrc   = bus.SelB ? ext : ram_rd;
  assign res    = bus.Op ? acc_q - bsrc : acc_q + bsrc;

  // Subtract overflows when signs differ and the result leaves Acc's sign.
  always_comb begin
    alu_ovf = 1'b0;
    if (bus.Op)
      alu_ovf = (acc_q[B-1] != bsrc[B-1]) &&
                (res[B-1] != acc_q[B-1]);
    else
      alu_ovf = (acc_q[B-1] == bsrc[B-1]) &&
                (res[B-1] != acc_q[B-1]);
  end

  always_comb begin
    acc_d = acc_q;
    unique case (bus.SelA)
      2'b00:   acc_d = ram_rd;
      2'b01:   acc_d = ext;
      2'b10:   acc_d = res;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      dbg_data <= '0;
    end else begin
      if (bus.WrAcc) acc_q <= acc_d;
      if (bus.WrAcc && bus.SelA == 2'b10 && alu_ovf)
        ovf_q <= 1'b1;
      dbg_data <= mem[dbg_addr];
    end
  end

  // RAM is not cleared; writes are simply blocked while reset is low.
  always_ff @(posedge clk) begin
    if (reset && bus.WrRam)
      mem[bus.Operand] <= acc_q;
  end

  assign bus.Acc  = acc_q;
  assign bus.Zero = (acc_q == '0);
  assign bus.Neg  = acc_q[B-1];
  assign bus.Ovf  = ovf_q;

endmodule

// File: doc/datapath.md
# datapath

Execution datapath of the accumulator processor, directly downstream of the control unit. It consumes the control unit's per-instruction decode (SelA, SelB, WrAcc, Op, WrRam, RdRam) and operand field. It holds the 16-bit accumulator, an add/sub ALU, 11-to-16 sign extension, the 2^W-word data RAM and the status flags. A registered debug read port lets a bench inspect RAM without disturbing execution.

## Interface

Parameters:
- B, 16, data/accumulator width
- W, 11, operand and data-RAM address width; RAM depth is 2^W words

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- SelA  in  2  accumulator source: 00 RAM data, 01 sign-extended operand, 10 ALU result, 11 hold
- SelB  in  1  ALU second operand: 0 RAM data, 1 sign-extended operand
- WrAcc  in  1  load accumulator from SelA source at next edge
- Op  in  1  ALU operation: 0 add, 1 subtract (Acc − B-operand)
- WrRam  in  1  write accumulator to RAM[Operand] at next edge
- RdRam  in  1  enables RAM data onto the A/B muxes
- Operand  in  W  immediate value or RAM address
- Acc  out  B  accumulator register
- Zero  out  1  Acc == 0
- Neg  out  1  Acc[B-1]
- Ovf  out  1  sticky signed-overflow flag
- dbg_addr  in  W  debug read address
- dbg_data  out  B  RAM[dbg_addr], registered

## Operation

- Sign extension: ext = {(B−W) copies of Operand[W-1], Operand}. Example: 11'h7FD → 16'hFFFD.
- RAM read is combinational at address Operand. The value presented to the muxes is RAM[Operand] when RdRam=1 and 16'h0000 when RdRam=0.
- ALU: res = Acc + bsrc (Op=0) or Acc − bsrc (Op=1), modulo 2^B.
- Signed overflow:
  - add: operands share a sign and res sign differs.
  - sub: operands differ in sign and res sign differs from Acc.
- Accumulator: on an edge with WrAcc=1, Acc ← selected source. SelA=11 or WrAcc=0 holds the value.
- Ovf sets on an edge where WrAcc=1, SelA=10 and the ALU overflows. It clears only on reset.
- RAM write: on an edge with WrRam=1, RAM[Operand] ← Acc, using the pre-edge value.
- Zero and Neg are combinational from the Acc register, so they are effectively registered.
- Debug port: dbg_data ← RAM[dbg_addr] every edge. It is independent of all control inputs.
- There is no internal FSM. State consists of Acc, Ovf, dbg_data and the RAM array. One instruction completes per cycle.

## Timing

- Reset values (reset=0, applied asynchronously): Acc=0, Ovf=0, dbg_data=0, hence Zero=1 and Neg=0.
- RAM contents are not reset. RAM writes are suppressed while reset=0.
- Reset asserted mid-instruction: Acc clears immediately. A pending WrRam in that cycle is dropped.
- Latency:
  - Acc, Ovf and RAM update at the edge ending the instruction cycle.
  - Zero and Neg follow Acc in the same cycle.
  - dbg_data is valid one edge after dbg_addr.
- WrAcc=1 and WrRam=1 in the same cycle: RAM gets the old Acc and Acc gets the new value.
- Read and write to the same address in the same cycle: the mux sees the old RAM content. The new content is visible the next cycle.
- A dbg_addr equal to a same-cycle write address returns the old content. The new content appears the following edge.
- Address wrap: none. Operand spans exactly 0..2^W−1.
- Control inputs are assumed stable by the control unit before each rising edge. No handshake is required.

## Test plan

- Reset/load immediate:
  - Stimulus: hold reset=0, release, then SelA=01, WrAcc=1, Operand=5.
  - Required response: Acc=0 and Zero=1 during reset; Acc=16'h0005 and Zero=0 after the edge.
- Add negative immediate:
  - Stimulus: Acc=5, then SelA=10, SelB=1, Op=0, Operand=11'h7FD, WrAcc=1.
  - Required response: Acc=16'h0002, Ovf=0.
- Store/load/debug:
  - Stimulus: Acc=2, WrRam=1, Operand=7. Next cycle, set Acc=0 with an immediate. Then SelA=00, RdRam=1, Operand=7, WrAcc=1. Also drive dbg_addr=7.
  - Required response: Acc=16'h0002; dbg_data=16'h0002 one edge after dbg_addr=7.
- Subtract with RdRam gating:
  - Stimulus: RAM[7]=2, Acc=10, then SelA=10, SelB=0, Op=1, Operand=7, WrAcc=1.
  - Required response: with RdRam=1, Acc=8. Repeating with RdRam=0 gives Acc=8 unchanged, since 8 − 0 = 8.
- Overflow:
  - Stimulus: Acc=1023, then six rounds of (WrRam to address 0; add RAM[0]).
  - Required response: after 5 rounds, Acc=16'h7FE0 and Ovf=0. After 6 rounds, Acc=16'hFFC0, Neg=1 and Ovf=1. Ovf stays 1 through later instructions until reset.
- Simultaneous write, and reset mid-run:
  - Stimulus 1: Acc=8, WrRam=1 and WrAcc=1 with SelA=01 and Operand=3 in the same cycle.
  - Required response 1: RAM[3]=8 and Acc=3.
  - Stimulus 2: pulse reset=0 mid-cycle with WrRam=1 pending.
  - Required response 2: Acc=0 and Ovf=0 immediately; the targeted RAM word is unchanged.
